// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic interpolation sequencer.
package bicubic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_HPASS,
      ST_VPASS,
      ST_SAMPLE,
      ST_OUT
   } state_t;

   // Tap offsets relative to the base coordinate: taps sit at -1, 0, +1, +2
   localparam int TAP_FIRST   = -1;
   localparam int TAP_LAST    = 2;
   localparam int NUM_ROWS    = TAP_LAST - TAP_FIRST + 1;

   localparam int ENG_PHASES  = 5;
   localparam int PREP_CYCLES = 4;

   // Request acceptance to first out_valid cycle
   localparam int LAT         = 31;

   // Q0.8 product rounded back to Q0.8; operands are at most 255 so the
   // rounded sum cannot overflow 16 bits
   function automatic logic [7:0] q8_round(input logic [15:0] prod);
      logic [15:0] s;
      s = prod + 16'd128;
      return s[15:8];
   endfunction

endpackage

// File: rtl/bicubic_sequencer_if.sv
// Bundle of request, line-buffer read, engine and result signals.
// master: pixel-loop controller / line buffer / engine side.
// slave:  the sequencer itself.
interface bicubic_sequencer_if #(
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] base_x;
   logic [CW-1:0] base_y;
   logic [7:0]    frac_x;
   logic [7:0]    frac_y;

   logic          rd_en;
   logic [CW-1:0] rd_x;
   logic [CW-1:0] rd_y;
   logic [7:0]    rd_data;

   logic [23:0]   eng_x;
   logic [7:0]    eng_p;
   logic [2:0]    eng_cnt;
   logic [7:0]    eng_out;

   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_pix;

   modport master (
      output in_valid, base_x, base_y, frac_x, frac_y,
      output rd_data, eng_out, out_ready,
      input  in_ready, rd_en, rd_x, rd_y,
      input  eng_x, eng_p, eng_cnt, out_valid, out_pix
   );

   modport slave (
      input  in_valid, base_x, base_y, frac_x, frac_y,
      input  rd_data, eng_out, out_ready,
      output in_ready, rd_en, rd_x, rd_y,
      output eng_x, eng_p, eng_cnt, out_valid, out_pix
   );

endinterface

// File: rtl/bicubic_coord_clamp.sv
// Adds a small signed tap offset to an unsigned coordinate and clamps the
// result into [0, LIM-1].
module bicubic_coord_clamp #(
   parameter int CW  = 8,
   parameter int LIM = 256
) (
   input  logic [CW-1:0]     base,
   input  logic signed [2:0] offset,
   output logic [CW-1:0]     coord
);
   // Two guard bits: one for the sign, one so base+2 at the top of the
   // range cannot wrap around into a negative value
   localparam int SW = CW + 2;
   localparam logic signed [SW-1:0] LIM_S = SW'(LIM);
   localparam logic [CW-1:0]        MAX_C = CW'(LIM - 1);

   logic signed [SW-1:0] sum;

   assign sum = $signed({2'b00, base}) + $signed({{(SW-3){offset[2]}}, offset});

   // Clamp low to zero and high to the last valid pixel
   always_comb begin
      coord = sum[CW-1:0];
      if (sum[SW-1]) begin
         coord = '0;
      end else if (sum >= LIM_S) begin
         coord = MAX_C;
      end
   end

endmodule

// File: rtl/bicubic_sequencer.sv
// Sequences one 2-D Catmull-Rom interpolation on the shared cubic engine:
// weight preparation, four horizontal passes over the clamped 4x4
// neighbourhood, one vertical pass over the row results, then output.
module bicubic_sequencer
   import bicubic_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int CW    = 8
) (
   input logic                clk,
   input logic                rst,
   bicubic_sequencer_if.slave bus
);

   localparam logic [2:0] LAST_PHASE = 3'(ENG_PHASES - 1);
   localparam logic [2:0] LAST_PREP  = 3'(PREP_CYCLES - 1);
   localparam logic [1:0] LAST_ROW   = 2'(NUM_ROWS - 1);

   state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [1:0] row, row_nxt;

   logic [CW-1:0] bx, by;
   logic [7:0]    tx, ty, sqx, cux, sqy, cuy;
   logic [7:0]    h_buf [0:3];
   logic [7:0]    out_pix_q;

   logic          in_ready_c;
   logic          accept;

   logic [7:0]    mul_a, mul_b;
   logic [15:0]   mul_prod;
   logic [7:0]    mul_rnd;

   logic signed [2:0] col_off, row_off;
   logic [CW-1:0]     clamp_x, clamp_y;

   logic          rd_en_c;
   logic [23:0]   eng_x_c;
   logic [7:0]    eng_p_c;
   logic [2:0]    eng_cnt_c;

   // A new request can slip in on the same cycle the previous result leaves
   assign in_ready_c = (state == ST_IDLE) || (state == ST_OUT && bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;

   // Column tap follows the engine phase (phase 0 reads tap -1), row tap
   // follows the pass index
   assign col_off = $signed({1'b0, cnt[1:0]} + 3'(TAP_FIRST));
   assign row_off = $signed({1'b0, row} + 3'(TAP_FIRST));

   bicubic_coord_clamp #(.CW(CW), .LIM(IMG_W)) u_clamp_x (
      .base   (bx),
      .offset (col_off),
      .coord  (clamp_x)
   );

   bicubic_coord_clamp #(.CW(CW), .LIM(IMG_H)) u_clamp_y (
      .base   (by),
      .offset (row_off),
      .coord  (clamp_y)
   );

   // Single shared multiplier: squares then cubes, x before y
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (cnt[1:0])
         2'd0: begin mul_a = tx;  mul_b = tx; end
         2'd1: begin mul_a = sqx; mul_b = tx; end
         2'd2: begin mul_a = ty;  mul_b = ty; end
         2'd3: begin mul_a = sqy; mul_b = ty; end
         default: ;
      endcase
   end

   assign mul_prod = {8'd0, mul_a} * {8'd0, mul_b};
   assign mul_rnd  = q8_round(mul_prod);

   // State, phase and row registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         row   <= row_nxt;
      end
   end

   // Next-state logic: fixed-length PREP, 4x5-cycle HPASS, 5-cycle VPASS
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      row_nxt   = row;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_PREP;
               cnt_nxt   = '0;
            end
         end
         ST_PREP: begin
            if (cnt == LAST_PREP) begin
               state_nxt = ST_HPASS;
               cnt_nxt   = '0;
               row_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         ST_HPASS: begin
            if (cnt == LAST_PHASE) begin
               cnt_nxt = '0;
               row_nxt = row + 2'd1;
               if (row == LAST_ROW) begin
                  state_nxt = ST_VPASS;
               end
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         ST_VPASS: begin
            if (cnt == LAST_PHASE) begin
               state_nxt = ST_SAMPLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         ST_SAMPLE: begin
            state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               state_nxt = accept ? ST_PREP : ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            row_nxt   = '0;
         end
      endcase
   end

   // Request capture, weight preparation, row buffer and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         bx        <= '0;
         by        <= '0;
         tx        <= '0;
         ty        <= '0;
         sqx       <= '0;
         cux       <= '0;
         sqy       <= '0;
         cuy       <= '0;
         out_pix_q <= '0;
         for (int i = 0; i < 4; i++) begin
            h_buf[i] <= '0;
         end
      end else begin
         if (accept) begin
            bx <= bus.base_x;
            by <= bus.base_y;
            tx <= bus.frac_x;
            ty <= bus.frac_y;
         end
         if (state == ST_PREP) begin
            case (cnt[1:0])
               2'd0: sqx <= mul_rnd;
               2'd1: cux <= mul_rnd;
               2'd2: sqy <= mul_rnd;
               2'd3: cuy <= mul_rnd;
               default: ;
            endcase
         end
         if (state == ST_HPASS && cnt == 3'd0 && row != 2'd0) begin
            h_buf[row - 2'd1] <= bus.eng_out;
         end
         if (state == ST_VPASS && cnt == 3'd0) begin
            h_buf[3] <= bus.eng_out;
         end
         if (state == ST_SAMPLE) begin
            out_pix_q <= bus.eng_out;
         end
      end
   end

   // Engine and read-port drive; everything is quiet outside the passes
   always_comb begin
      rd_en_c   = 1'b0;
      eng_x_c   = '0;
      eng_p_c   = '0;
      eng_cnt_c = '0;
      case (state)
         ST_HPASS: begin
            eng_x_c   = {tx, sqx, cux};
            eng_cnt_c = cnt;
            rd_en_c   = (cnt != LAST_PHASE);
            if (cnt != 3'd0) begin
               eng_p_c = bus.rd_data;
            end
         end
         ST_VPASS: begin
            eng_x_c   = {ty, sqy, cuy};
            eng_cnt_c = cnt;
            if (cnt != 3'd0) begin
               eng_p_c = h_buf[2'(cnt - 3'd1)];
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.rd_en     = rd_en_c;
   assign bus.rd_x      = rd_en_c ? clamp_x : '0;
   assign bus.rd_y      = rd_en_c ? clamp_y : '0;
   assign bus.eng_x     = eng_x_c;
   assign bus.eng_p     = eng_p_c;
   assign bus.eng_cnt   = eng_cnt_c;
   assign bus.out_valid = (state == ST_OUT);
   assign bus.out_pix   = out_pix_q;

endmodule

// File: tb/tb_bicubic_sequencer.sv
// Directed bench for bicubic_sequencer with a behavioural line buffer,
// a behavioural cubic engine and a golden 2-D interpolation model.
module tb_bicubic_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bicubic_sequencer_if #(.CW(8)) bus ();

   bicubic_sequencer #(.IMG_W(256), .IMG_H(256), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int rd_count = 0;
   int img_mode = 0;
   int img_seed = 0;

   logic [7:0]  tap0, tap1, tap2;
   logic [15:0] rd_log [$];
   logic [23:0] ex_log [$];

   function automatic int clampc(int v, int lim);
      if (v < 0) return 0;
      if (v > lim - 1) return lim - 1;
      return v;
   endfunction

   function automatic int pix_at(int x, int y);
      int h;
      if (img_mode == 0) return 0;
      if (img_mode == 2) return 255;
      h = x * 1103 + y * 2957 + img_seed * 7919;
      h = h ^ (h >> 7) ^ (h >> 13);
      return h & 255;
   endfunction

   function automatic logic [7:0] eng_f(int p0, int p1, int p2, int p3, int t, int t2, int t3);
      int num;
      num = 512 * p1 + (p2 - p0) * t + (2 * p0 - 5 * p1 + 4 * p2 - p3) * t2
            + (-p0 + 3 * p1 - 3 * p2 + p3) * t3 + 256;
      num = num >>> 9;
      if (num < 0) return 8'd0;
      if (num > 255) return 8'd255;
      return num[7:0];
   endfunction

   function automatic logic [7:0] golden(int bx, int by, int fx, int fy);
      int sqx, cux, sqy, cuy;
      int p[4];
      int h[4];
      sqx = (fx * fx + 128) >> 8;
      cux = (sqx * fx + 128) >> 8;
      sqy = (fy * fy + 128) >> 8;
      cuy = (sqy * fy + 128) >> 8;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            p[c] = pix_at(clampc(bx + c - 1, 256), clampc(by + r - 1, 256));
         end
         h[r] = int'(eng_f(p[0], p[1], p[2], p[3], fx, sqx, cux));
      end
      return eng_f(h[0], h[1], h[2], h[3], fy, sqy, cuy);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Line buffer: one-cycle read latency, junk when no read was issued
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data <= 8'(pix_at(int'(bus.rd_x), int'(bus.rd_y)));
         rd_log.push_back({bus.rd_x, bus.rd_y});
         ex_log.push_back(bus.eng_x);
         rd_count <= rd_count + 1;
      end else begin
         bus.rd_data <= 8'h5A;
      end
   end

   // Cubic engine: taps on phases 1..4, result valid the cycle after phase 4
   always @(posedge clk) begin
      case (bus.eng_cnt)
         3'd1: tap0 <= bus.eng_p;
         3'd2: tap1 <= bus.eng_p;
         3'd3: tap2 <= bus.eng_p;
         3'd4: bus.eng_out <= eng_f(int'(tap0), int'(tap1), int'(tap2), int'(bus.eng_p),
                                    int'(bus.eng_x[23:16]), int'(bus.eng_x[15:8]),
                                    int'(bus.eng_x[7:0]));
         default: ;
      endcase
   end

   task automatic issue(input int bx, input int by, input int fx, input int fy,
                        output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.base_x   = 8'(bx);
      bus.base_y   = 8'(by);
      bus.frac_x   = 8'(fx);
      bus.frac_y   = 8'(fy);
      #1;
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready) begin
            n  = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input int n, output logic [7:0] pix, output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      pix = 8'd0;
      for (int i = 0; i < 100; i++) begin
         if (bus.out_valid) begin
            lat = cyc - n;
            pix = bus.out_pix;
            ok  = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic run_one(input int bx, input int by, input int fx, input int fy,
                          output logic [7:0] pix, output int lat, output bit ok);
      int n;
      issue(bx, by, fx, fy, n, ok);
      pix = 8'd0;
      lat = 0;
      if (ok) collect(n, pix, lat, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
      total++; if (bus.out_pix !== 8'd0) $display("[TB] FAIL reset_out_pix: got %0d expected 0", bus.out_pix); else passed++;
      total++; if (bus.rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.rd_en); else passed++;
      total++; if ({bus.rd_x, bus.rd_y} !== 16'd0) $display("[TB] FAIL reset_rd_xy: got %h expected 0", {bus.rd_x, bus.rd_y}); else passed++;
      total++; if (bus.eng_cnt !== 3'd0) $display("[TB] FAIL reset_eng_cnt: got %0d expected 0", bus.eng_cnt); else passed++;
      total++; if (bus.eng_p !== 8'd0) $display("[TB] FAIL reset_eng_p: got %0d expected 0", bus.eng_p); else passed++;
      total++; if (bus.eng_x !== 24'd0) $display("[TB] FAIL reset_eng_x: got %h expected 0", bus.eng_x); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_order();
      logic [7:0] pix;
      int lat;
      bit ok;
      img_mode = 1;
      img_seed = 3;
      rd_log.delete();
      ex_log.delete();
      run_one(10, 10, 128, 128, pix, lat, ok);
      total++; if (ok !== 1'b1) $display("[TB] FAIL order_done: got %0d expected 1", ok); else passed++;
      total++; if (rd_log.size() != 16) $display("[TB] FAIL order_count: got %0d expected 16", rd_log.size()); else passed++;
      for (int i = 0; i < 16; i++) begin
         if (i < rd_log.size()) begin
            total++;
            if (rd_log[i] !== {8'(9 + i % 4), 8'(9 + i / 4)})
               $display("[TB] FAIL order_read%0d: got %h expected %h", i, rd_log[i], {8'(9 + i % 4), 8'(9 + i / 4)});
            else passed++;
            total++;
            if (ex_log[i] !== 24'h804020)
               $display("[TB] FAIL order_eng_x%0d: got %h expected 804020", i, ex_log[i]);
            else passed++;
         end
      end
      total++; if (pix !== golden(10, 10, 128, 128)) $display("[TB] FAIL order_pix: got %0d expected %0d", pix, golden(10, 10, 128, 128)); else passed++;
   endtask

   task automatic test_uniform();
      logic [7:0] pix;
      int lat;
      bit ok;
      img_mode = 0;
      run_one(40, 77, 37, 200, pix, lat, ok);
      total++; if (!ok || pix !== 8'd0) $display("[TB] FAIL uniform0_a: got %0d expected 0", pix); else passed++;
      run_one(200, 3, 255, 0, pix, lat, ok);
      total++; if (!ok || pix !== 8'd0) $display("[TB] FAIL uniform0_b: got %0d expected 0", pix); else passed++;
      img_mode = 2;
      run_one(128, 128, 90, 170, pix, lat, ok);
      total++; if (!ok || pix !== 8'd255) $display("[TB] FAIL uniform255: got %0d expected 255", pix); else passed++;
   endtask

   task automatic test_clamp_edges();
      logic [7:0] pix;
      int lat;
      bit ok;
      int bases [2];
      logic [15:0] exp_rd;
      bases[0] = 0;
      bases[1] = 255;
      img_mode = 1;
      img_seed = 11;
      for (int b = 0; b < 2; b++) begin
         rd_log.delete();
         run_one(bases[b], bases[b], 64, 192, pix, lat, ok);
         total++; if (rd_log.size() != 16) $display("[TB] FAIL clamp%0d_count: got %0d expected 16", bases[b], rd_log.size()); else passed++;
         for (int i = 0; i < 16; i++) begin
            if (i < rd_log.size()) begin
               exp_rd = {8'(clampc(bases[b] + i % 4 - 1, 256)), 8'(clampc(bases[b] + i / 4 - 1, 256))};
               total++;
               if (rd_log[i] !== exp_rd)
                  $display("[TB] FAIL clamp%0d_read%0d: got %h expected %h", bases[b], i, rd_log[i], exp_rd);
               else passed++;
            end
         end
         total++;
         if (!ok || pix !== golden(bases[b], bases[b], 64, 192))
            $display("[TB] FAIL clamp%0d_pix: got %0d expected %0d", bases[b], pix, golden(bases[b], bases[b], 64, 192));
         else passed++;
      end
   endtask

   task automatic test_latency_hold();
      int n, lat;
      bit ok, seen, early_ready, hold_bad;
      logic [7:0] pix0;
      img_mode = 1;
      img_seed = 21;
      issue(100, 50, 17, 230, n, ok);
      seen = 1'b0;
      early_ready = 1'b0;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            lat  = cyc - n;
            break;
         end
         if (bus.in_ready) early_ready = 1'b1;
         @(negedge clk);
      end
      total++; if (!seen || lat != 31) $display("[TB] FAIL latency: got %0d expected 31", lat); else passed++;
      total++; if (early_ready !== 1'b0) $display("[TB] FAIL busy_in_ready: got %b expected 0", early_ready); else passed++;
      pix0 = bus.out_pix;
      hold_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_pix !== pix0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_bad = 1'b1;
      end
      total++; if (hold_bad !== 1'b0) $display("[TB] FAIL hold_stable: got %b expected 0", hold_bad); else passed++;
      total++; if (pix0 !== golden(100, 50, 17, 230)) $display("[TB] FAIL hold_pix: got %0d expected %0d", pix0, golden(100, 50, 17, 230)); else passed++;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL drain_out_valid: got %b expected 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL drain_in_ready: got %b expected 1", bus.in_ready); else passed++;
   endtask

   task automatic test_back_to_back();
      int n1, n2, lat;
      bit ok, seen;
      logic [7:0] pix_a, pix_b;
      img_mode = 1;
      img_seed = 33;
      issue(20, 30, 77, 140, n1, ok);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++; if (!seen || cyc - n1 != 31) $display("[TB] FAIL b2b_first_latency: got %0d expected 31", cyc - n1); else passed++;
      pix_a = bus.out_pix;
      bus.in_valid  = 1'b1;
      bus.base_x    = 8'd250;
      bus.base_y    = 8'd1;
      bus.frac_x    = 8'd3;
      bus.frac_y    = 8'd251;
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready: got %b expected 1", bus.in_ready); else passed++;
      n2 = cyc;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_out_dropped: got %b expected 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL b2b_busy: got %b expected 0", bus.in_ready); else passed++;
      total++; if (pix_a !== golden(20, 30, 77, 140)) $display("[TB] FAIL b2b_pix_a: got %0d expected %0d", pix_a, golden(20, 30, 77, 140)); else passed++;
      collect(n2, pix_b, lat, ok);
      total++; if (!ok || lat != 31) $display("[TB] FAIL b2b_second_latency: got %0d expected 31", lat); else passed++;
      total++; if (pix_b !== golden(250, 1, 3, 251)) $display("[TB] FAIL b2b_pix_b: got %0d expected %0d", pix_b, golden(250, 1, 3, 251)); else passed++;
   endtask

   task automatic test_mid_reset();
      int n, lat, rd_before;
      bit ok;
      logic [7:0] pix;
      img_mode = 1;
      img_seed = 45;
      issue(60, 70, 33, 99, n, ok);
      while (cyc < n + 15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL mrst_out_valid: got %b expected 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL mrst_in_ready: got %b expected 1", bus.in_ready); else passed++;
      total++; if (bus.rd_en !== 1'b0) $display("[TB] FAIL mrst_rd_en: got %b expected 0", bus.rd_en); else passed++;
      total++; if (bus.eng_cnt !== 3'd0) $display("[TB] FAIL mrst_eng_cnt: got %0d expected 0", bus.eng_cnt); else passed++;
      total++; if (bus.eng_x !== 24'd0) $display("[TB] FAIL mrst_eng_x: got %h expected 0", bus.eng_x); else passed++;
      total++; if (bus.eng_p !== 8'd0) $display("[TB] FAIL mrst_eng_p: got %0d expected 0", bus.eng_p); else passed++;
      total++; if (bus.out_pix !== 8'd0) $display("[TB] FAIL mrst_out_pix: got %0d expected 0", bus.out_pix); else passed++;
      rst = 1'b0;
      rd_before = rd_count;
      repeat (20) @(negedge clk);
      total++; if (rd_count != rd_before) $display("[TB] FAIL mrst_no_reads: got %0d expected %0d", rd_count, rd_before); else passed++;
      run_one(5, 250, 210, 45, pix, lat, ok);
      total++; if (!ok || lat != 31) $display("[TB] FAIL mrst_latency: got %0d expected 31", lat); else passed++;
      total++; if (pix !== golden(5, 250, 210, 45)) $display("[TB] FAIL mrst_pix: got %0d expected %0d", pix, golden(5, 250, 210, 45)); else passed++;
   endtask

   task automatic test_random();
      int bx, by, fx, fy, lat;
      bit ok;
      logic [7:0] pix, exp_pix;
      img_mode = 1;
      for (int k = 0; k < 1000; k++) begin
         img_seed = k;
         bx = int'($urandom_range(0, 255));
         by = int'($urandom_range(0, 255));
         fx = int'($urandom_range(0, 255));
         fy = int'($urandom_range(0, 255));
         run_one(bx, by, fx, fy, pix, lat, ok);
         exp_pix = golden(bx, by, fx, fy);
         total++;
         if (!ok || pix !== exp_pix)
            $display("[TB] FAIL random%0d (%0d,%0d,%0d,%0d): got %0d expected %0d", k, bx, by, fx, fy, pix, exp_pix);
         else passed++;
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.base_x    = 8'd0;
      bus.base_y    = 8'd0;
      bus.frac_x    = 8'd0;
      bus.frac_y    = 8'd0;
      bus.rd_data   = 8'd0;
      bus.eng_out   = 8'd0;
      test_reset();
      test_read_order();
      test_uniform();
      test_clamp_edges();
      test_latency_hold();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
